// File: rtl/blake2b_pkg.sv
// Shared definitions for the BLAKE2b block controller.
//   W           : word width (64)
//   IV          : BLAKE2b initialisation vector, word k in [64k+63:64k]
//   state_t     : controller states FILL/HOLD/DISPATCH/BUSY/DONE
//   param_word  : parameter-block word P0 folded into h[0]
//   sat_bytes   : clamps a byte count to 0..8
//   byte_mask   : byte count -> 64-bit keep mask (byte 0 in [7:0])
package blake2b_pkg;

   localparam int unsigned W = 64;

   localparam logic [511:0] IV = {
      64'h5BE0CD19137E2179, 64'h1F83D9ABFB41BD6B,
      64'h9B05688C2B3E6C1F, 64'h510E527FADE682D1,
      64'hA54FF53A5F1D36F1, 64'h3C6EF372FE94F82B,
      64'hBB67AE8584CAA73B, 64'h6A09E667F3BCC908
   };

   typedef enum logic [2:0] {
      FILL,
      HOLD,
      DISPATCH,
      BUSY,
      DONE
   } state_t;

   function automatic logic [63:0] param_word(input logic [7:0] nn, input logic [7:0] kk);
      return 64'h0101_0000 ^ {48'd0, kk, 8'd0} ^ {56'd0, nn};
   endfunction

   function automatic logic [3:0] sat_bytes(input logic [3:0] b);
      return (b > 4'd8) ? 4'd8 : b;
   endfunction

   function automatic logic [63:0] byte_mask(input logic [3:0] nbytes);
      logic [63:0] m;
      m = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < 32'(nbytes)) m[8*i +: 8] = 8'hFF;
      end
      return m;
   endfunction

endpackage

// File: rtl/blake2b_block_ctrl_if.sv
// Bus bundle for blake2b_block_ctrl: message word stream, compression-core
// handshake and digest handshake.
//   slave  : the controller side
//   master : the feeder / core / digest-consumer side
// With BLAKE2B_KEYED_EN defined, key_len_i (7 bits) is added to the bundle.
interface blake2b_block_ctrl_if;
   import blake2b_pkg::*;

   logic             data_valid_i;
   logic             data_ready_o;
   logic [W-1:0]     data_i;
   logic             last_i;
   logic [3:0]       bytes_i;
`ifdef BLAKE2B_KEYED_EN
   logic [6:0]       key_len_i;
`endif
   logic             cmp_valid_o;
   logic [16*W-1:0]  cmp_m_o;
   logic [8*W-1:0]   cmp_h_o;
   logic [2*W-1:0]   cmp_t_o;
   logic             cmp_f_o;
   logic             cmp_valid_i;
   logic [8*W-1:0]   cmp_h_i;
   logic             digest_valid_o;
   logic             digest_ready_i;
   logic [8*W-1:0]   digest_o;

   modport slave (
      input  data_valid_i, data_i, last_i, bytes_i,
`ifdef BLAKE2B_KEYED_EN
      input  key_len_i,
`endif
      input  cmp_valid_i, cmp_h_i, digest_ready_i,
      output data_ready_o, cmp_valid_o, cmp_m_o, cmp_h_o, cmp_t_o, cmp_f_o,
      output digest_valid_o, digest_o
   );

   modport master (
      output data_valid_i, data_i, last_i, bytes_i,
`ifdef BLAKE2B_KEYED_EN
      output key_len_i,
`endif
      output cmp_valid_i, cmp_h_i, digest_ready_i,
      input  data_ready_o, cmp_valid_o, cmp_m_o, cmp_h_o, cmp_t_o, cmp_f_o,
      input  digest_valid_o, digest_o
   );

endinterface

// File: rtl/blake2b_msg_buf.sv
// 16 x 64-bit message block buffer.
//   clk, reset : clock, asynchronous active-high reset
//   i_wr_en    : write i_data at the current index and advance
//   i_data     : message word, byte 0 in [7:0]
//   i_last     : word is the final one; bytes above i_bytes are zeroed
//   i_bytes    : valid bytes in the final word (saturated to 8)
//   i_clear    : zero the whole block and rewind the index
//   o_full     : all 16 words written
//   o_idx      : next write index
//   o_block    : 1024-bit block, word k in [64k+63:64k]
// Words never written stay zero because the buffer is cleared after every
// dispatch, which provides the tail padding for free.
module blake2b_msg_buf
   import blake2b_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            i_wr_en,
   input  logic [W-1:0]    i_data,
   input  logic            i_last,
   input  logic [3:0]      i_bytes,
   input  logic            i_clear,
   output logic            o_full,
   output logic [3:0]      o_idx,
   output logic [16*W-1:0] o_block
);

   logic [16*W-1:0] r_block;
   logic [4:0]      r_cnt;
   logic [W-1:0]    w_word;
   logic [9:0]      w_base;

   always_comb begin
      w_word = i_last ? (i_data & byte_mask(sat_bytes(i_bytes))) : i_data;
      w_base = {r_cnt[3:0], 6'd0};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_block <= '0;
         r_cnt   <= '0;
      end else if (i_clear) begin
         r_block <= '0;
         r_cnt   <= '0;
      end else if (i_wr_en && !r_cnt[4]) begin
         r_block[w_base +: W] <= w_word;
         r_cnt                <= r_cnt + 5'd1;
      end
   end

   assign o_full  = r_cnt[4];
   assign o_idx   = r_cnt[3:0];
   assign o_block = r_block;

endmodule

// File: rtl/blake2b_block_ctrl.sv
// BLAKE2b block feeder and chaining controller.
// Packs a 64-bit word stream into 128-byte blocks, tracks the byte offset t,
// decides the final-block flag f, owns the chaining state h and presents the
// digest with a valid/ready handshake.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : blake2b_block_ctrl_if.slave (word stream, core handshake, digest)
// Parameters: W (word width, 64), NN (digest bytes, 1..64).
// Optional macro BLAKE2B_KEYED_EN adds bus.key_len_i, sampled on the first
// word of a message and folded into h[0]; otherwise the key length is 0.
module blake2b_block_ctrl
   import blake2b_pkg::*;
#(
   parameter int unsigned W  = 64,
   parameter int unsigned NN = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   blake2b_block_ctrl_if.slave  bus
);

   localparam int unsigned  TW     = 2 * W;
   localparam logic [7:0]   NN_B   = 8'(NN);
   localparam logic [511:0] H_INIT = IV ^ {448'd0, param_word(NN_B, 8'd0)};

   state_t          r_state;
   logic [TW-1:0]   r_t;
   logic            r_f;
   logic [8*W-1:0]  r_h;
   logic            r_cmp_valid;
   logic            r_digest_valid;

   logic [3:0]      w_bsat;
   logic [3:0]      w_idx;
   logic            w_full;
   logic            w_hold_final;
   logic            w_wr_en;
   logic            w_clear;
   logic [16*W-1:0] w_block;

   always_comb begin
      w_bsat       = sat_bytes(bus.bytes_i);
      w_hold_final = bus.data_valid_i && bus.last_i && (w_bsat == 4'd0);
      w_wr_en      = (r_state == FILL) && bus.data_valid_i && !w_full;
      w_clear      = (r_state == DISPATCH);
   end

   // In HOLD the only word that may be consumed is an empty final word; it
   // marks the held block as final without contributing bytes, so ready is
   // raised combinationally for exactly that case.
   assign bus.data_ready_o = (r_state == FILL) || ((r_state == HOLD) && w_hold_final);

`ifdef BLAKE2B_KEYED_EN
   logic [7:0] w_kk;
   logic       w_first;
   always_comb begin
      w_kk    = (bus.key_len_i > 7'd64) ? 8'd64 : {1'b0, bus.key_len_i};
      w_first = (w_idx == 4'd0) && !w_full && (r_t == '0);
   end
`endif

   blake2b_msg_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .i_wr_en (w_wr_en),
      .i_data  (bus.data_i),
      .i_last  (bus.last_i),
      .i_bytes (bus.bytes_i),
      .i_clear (w_clear),
      .o_full  (w_full),
      .o_idx   (w_idx),
      .o_block (w_block)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= FILL;
         r_t            <= '0;
         r_f            <= 1'b0;
         r_h            <= H_INIT;
         r_cmp_valid    <= 1'b0;
         r_digest_valid <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (bus.data_valid_i) begin
`ifdef BLAKE2B_KEYED_EN
                  if (w_first) r_h[W-1:0] <= IV[W-1:0] ^ param_word(NN_B, w_kk);
`endif
                  if (bus.last_i) begin
                     r_t         <= r_t + TW'(w_bsat);
                     r_f         <= 1'b1;
                     r_cmp_valid <= 1'b1;
                     r_state     <= DISPATCH;
                  end else begin
                     r_t <= r_t + TW'(8);
                     if (w_idx == 4'd15) r_state <= HOLD;
                  end
               end
            end
            HOLD: begin
               // A word that still carries bytes belongs to the next block,
               // so it is left on the bus until FILL resumes.
               if (bus.data_valid_i) begin
                  r_f         <= w_hold_final;
                  r_cmp_valid <= 1'b1;
                  r_state     <= DISPATCH;
               end
            end
            DISPATCH: begin
               r_cmp_valid <= 1'b0;
               r_state     <= BUSY;
            end
            BUSY: begin
               if (bus.cmp_valid_i) begin
                  r_h <= bus.cmp_h_i;
                  if (r_f) begin
                     r_digest_valid <= 1'b1;
                     r_state        <= DONE;
                  end else begin
                     r_state <= FILL;
                  end
               end
            end
            DONE: begin
               if (bus.digest_ready_i) begin
                  r_h            <= H_INIT;
                  r_t            <= '0;
                  r_f            <= 1'b0;
                  r_digest_valid <= 1'b0;
                  r_state        <= FILL;
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign bus.cmp_valid_o    = r_cmp_valid;
   assign bus.cmp_m_o        = w_block;
   assign bus.cmp_h_o        = r_h;
   assign bus.cmp_t_o        = r_t;
   assign bus.cmp_f_o        = r_f;
   assign bus.digest_valid_o = r_digest_valid;
   assign bus.digest_o       = r_h;

endmodule

// File: tb/tb_blake2b_block_ctrl.sv
module tb_blake2b_block_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   blake2b_block_ctrl_if bus();

   blake2b_block_ctrl #(.W(64), .NN(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   localparam logic [511:0] H_INIT = {
      64'h5BE0CD19137E2179, 64'h1F83D9ABFB41BD6B,
      64'h9B05688C2B3E6C1F, 64'h510E527FADE682D1,
      64'hA54FF53A5F1D36F1, 64'h3C6EF372FE94F82B,
      64'hBB67AE8584CAA73B, 64'h6A09E667F2BDC948
   };

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned stalls = 0;

   // Stand-in compression core: any deterministic mix of h, t and f is enough
   // to show the controller routes the core's result into h and the digest.
   function automatic logic [511:0] core_model(input logic [511:0] h, input logic [127:0] t, input logic f);
      return h ^ {4{t}} ^ (f ? {8{64'hA5A55A5A0F0FF0F0}} : 512'd0);
   endfunction

   function automatic logic [63:0] word_k(input int unsigned k);
      logic [7:0] v;
      v = 8'(k) + 8'h10;
      return {8{v}};
   endfunction

   task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- mock core ----------------
   logic [1023:0] cap_m [64];
   logic [127:0]  cap_t [64];
   logic          cap_f [64];
   logic [511:0]  cap_h [64];
   int unsigned   cap_count  = 0;
   int unsigned   h_unstable = 0;

   initial begin
      logic [511:0] hc;
      logic [127:0] tc;
      logic         fc;
      bus.cmp_valid_i = 1'b0;
      bus.cmp_h_i     = '0;
      forever begin
         @(negedge clk);
         if (bus.cmp_valid_o) begin
            hc = bus.cmp_h_o;
            tc = bus.cmp_t_o;
            fc = bus.cmp_f_o;
            if (cap_count < 64) begin
               cap_m[cap_count] = bus.cmp_m_o;
               cap_t[cap_count] = tc;
               cap_f[cap_count] = fc;
               cap_h[cap_count] = hc;
            end
            cap_count++;
            repeat (3) begin
               @(negedge clk);
               if (!reset && bus.cmp_h_o !== hc) h_unstable++;
            end
            @(negedge clk);
            bus.cmp_h_i     = core_model(hc, tc, fc);
            bus.cmp_valid_i = 1'b1;
            @(negedge clk);
            bus.cmp_valid_i = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] b);
      int unsigned n;
      n = 0;
      @(negedge clk);
      bus.data_valid_i = 1'b1;
      bus.data_i       = d;
      bus.last_i       = l;
      bus.bytes_i      = b;
      #1;
      while (!bus.data_ready_o && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n != 0) stalls++;
      if (!bus.data_ready_o) begin
         checks++;
         errors++;
         $display("FAIL send_word_timeout: data_ready_o %0b required 1", bus.data_ready_o);
      end else begin
         @(posedge clk);
         #1;
      end
      bus.data_valid_i = 1'b0;
      bus.last_i       = 1'b0;
      bus.bytes_i      = '0;
   endtask

   task automatic wait_digest();
      int unsigned n;
      n = 0;
      while (!bus.digest_valid_o && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!bus.digest_valid_o) begin
         checks++;
         errors++;
         $display("FAIL digest_timeout: digest_valid_o %0b required 1", bus.digest_valid_o);
      end
   endtask

   task automatic ack_digest();
      @(negedge clk);
      bus.digest_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.digest_ready_i = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [63:0]  data;
      logic [3:0]   bytes;
      logic [63:0]  exp_w0;
      logic [127:0] exp_t;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int unsigned   base;
      logic [1023:0] exp_blk;
      logic [511:0]  h_mid;

      bus.data_valid_i   = 1'b0;
      bus.data_i         = '0;
      bus.last_i         = 1'b0;
      bus.bytes_i        = '0;
      bus.digest_ready_i = 1'b0;

      tbl[0]  = '{64'hF0E1D2C3B4A59687, 4'd0,  64'h0,                128'd0};
      tbl[1]  = '{64'hF0E1D2C3B4A59687, 4'd1,  64'h87,               128'd1};
      tbl[2]  = '{64'hF0E1D2C3B4A59687, 4'd2,  64'h9687,             128'd2};
      tbl[3]  = '{64'hF0E1D2C3B4A59687, 4'd3,  64'hA59687,           128'd3};
      tbl[4]  = '{64'hF0E1D2C3B4A59687, 4'd4,  64'hB4A59687,         128'd4};
      tbl[5]  = '{64'hF0E1D2C3B4A59687, 4'd5,  64'hC3B4A59687,       128'd5};
      tbl[6]  = '{64'hF0E1D2C3B4A59687, 4'd6,  64'hD2C3B4A59687,     128'd6};
      tbl[7]  = '{64'hF0E1D2C3B4A59687, 4'd7,  64'hE1D2C3B4A59687,   128'd7};
      tbl[8]  = '{64'hF0E1D2C3B4A59687, 4'd8,  64'hF0E1D2C3B4A59687, 128'd8};
      tbl[9]  = '{64'hF0E1D2C3B4A59687, 4'd12, 64'hF0E1D2C3B4A59687, 128'd8};
      tbl[10] = '{64'h0000000000636261, 4'd3,  64'h636261,           128'd3};

      // reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready",     bus.data_ready_o,   1);
      check("rst_cmp_valid", bus.cmp_valid_o,    0);
      check("rst_dig_valid", bus.digest_valid_o, 0);
      check("rst_h",         bus.cmp_h_o,        H_INIT);
      check("rst_t",         bus.cmp_t_o,        0);
      @(negedge clk);
      reset = 1'b0;

      // single-word messages, empty message first
      for (int i = 0; i < 11; i++) begin
         base = cap_count;
         send_word(tbl[i].data, 1'b1, tbl[i].bytes);
         wait_digest();
         check($sformatf("v%0d_blocks", i), 1024'(cap_count - base), 1);
         check($sformatf("v%0d_m", i),      cap_m[base], {960'd0, tbl[i].exp_w0});
         check($sformatf("v%0d_t", i),      cap_t[base], tbl[i].exp_t);
         check($sformatf("v%0d_f", i),      cap_f[base], 1);
         check($sformatf("v%0d_h", i),      cap_h[base], H_INIT);
         check($sformatf("v%0d_digest", i), bus.digest_o, core_model(H_INIT, tbl[i].exp_t, 1'b1));
         ack_digest();
      end

      // exactly 128 bytes: final flag on word 15, no HOLD stall
      exp_blk = '0;
      for (int k = 0; k < 16; k++) exp_blk[64*k +: 64] = word_k(k);
      base   = cap_count;
      stalls = 0;
      for (int k = 0; k < 16; k++) send_word(word_k(k), (k == 15), 4'd8);
      wait_digest();
      check("b128_stalls", stalls, 0);
      check("b128_blocks", 1024'(cap_count - base), 1);
      check("b128_m",      cap_m[base], exp_blk);
      check("b128_t",      cap_t[base], 128);
      check("b128_f",      cap_f[base], 1);
      check("b128_digest", bus.digest_o, core_model(H_INIT, 128, 1'b1));
      ack_digest();

      // 129 bytes: HOLD then non-final dispatch, second block carries one byte
      base   = cap_count;
      stalls = 0;
      for (int k = 0; k < 16; k++) send_word(word_k(k), 1'b0, 4'd0);
      send_word(64'hDEADBEEFCAFE0080, 1'b1, 4'd1);
      wait_digest();
      h_mid = core_model(H_INIT, 128, 1'b0);
      check("b129_stalled", (stalls != 0), 1);
      check("b129_blocks",  1024'(cap_count - base), 2);
      check("b129_m0",      cap_m[base], exp_blk);
      check("b129_t0",      cap_t[base], 128);
      check("b129_f0",      cap_f[base], 0);
      check("b129_h0",      cap_h[base], H_INIT);
      check("b129_m1",      cap_m[base+1], 1024'h80);
      check("b129_t1",      cap_t[base+1], 129);
      check("b129_f1",      cap_f[base+1], 1);
      check("b129_h1",      cap_h[base+1], h_mid);
      check("b129_digest",  bus.digest_o, core_model(h_mid, 129, 1'b1));
      ack_digest();

      // 16 full words then an empty final word: consumed, single final block
      base   = cap_count;
      stalls = 0;
      for (int k = 0; k < 16; k++) send_word(word_k(k), 1'b0, 4'd0);
      send_word(64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd0);
      wait_digest();
      check("b16z_stalls", stalls, 0);
      check("b16z_m",      cap_m[base], exp_blk);
      check("b16z_t",      cap_t[base], 128);
      check("b16z_f",      cap_f[base], 1);
      check("b16z_digest", bus.digest_o, core_model(H_INIT, 128, 1'b1));
      ack_digest();
      repeat (10) @(negedge clk);
      check("b16z_blocks", 1024'(cap_count - base), 1);

      // digest backpressure with a word waiting on the bus
      send_word(64'h636261, 1'b1, 4'd3);
      wait_digest();
      @(negedge clk);
      bus.data_valid_i = 1'b1;
      bus.data_i       = 64'h1122334455667788;
      bus.last_i       = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         check($sformatf("bp%0d_digest", c), bus.digest_o, core_model(H_INIT, 3, 1'b1));
         check($sformatf("bp%0d_ready", c),  bus.data_ready_o, 0);
         @(negedge clk);
      end
      bus.digest_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.digest_ready_i = 1'b0;
      bus.data_valid_i   = 1'b0;
      check("bp_valid_clr", bus.digest_valid_o, 0);
      check("bp_ready_set", bus.data_ready_o,   1);
      check("bp_h_reinit",  bus.cmp_h_o,        H_INIT);
      base = cap_count;
      send_word(64'h636261, 1'b1, 4'd3);
      wait_digest();
      check("bp_next_h0", cap_h[base][63:0], 64'h6A09E667F2BDC948);
      check("bp_next_m",  cap_m[base], 1024'h636261);
      check("bp_next_t",  cap_t[base], 3);
      ack_digest();

      // reset while the core is busy; its late completion must be ignored
      base = cap_count;
      send_word(64'h0102030405060708, 1'b1, 4'd8);
      for (int n = 0; n < 50 && cap_count == base; n++) begin
         @(negedge clk);
         #1;
      end
      check("rb_dispatched", 1024'(cap_count - base), 1);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rb_ready",     bus.data_ready_o,   1);
      check("rb_cmp_valid", bus.cmp_valid_o,    0);
      check("rb_dig_valid", bus.digest_valid_o, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("rb%0d_dig_valid", c), bus.digest_valid_o, 0);
         check($sformatf("rb%0d_cmp_valid", c), bus.cmp_valid_o,    0);
         check($sformatf("rb%0d_ready", c),     bus.data_ready_o,   1);
      end
      check("rb_h_after", bus.cmp_h_o, H_INIT);
      base = cap_count;
      send_word(64'h636261, 1'b1, 4'd3);
      wait_digest();
      check("rb_next_t",      cap_t[base], 3);
      check("rb_next_h",      cap_h[base], H_INIT);
      check("rb_next_digest", bus.digest_o, core_model(H_INIT, 3, 1'b1));
      ack_digest();

      check("h_stable_busy", h_unstable, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation time exceeded, %0d failures so far", errors);
      $fatal(1, "timeout");
   end

endmodule
